data_sram_like_if: RTL and testbench
====================================

// Module: data_sram_like_if
// PURPOSE
//  Data-side bus front end of the M stage: turns the per-instruction data access
//  (byte-lane write enables, aligned write data, address, size) into a sram-like
//  request/addr_ok/data_ok transaction and stalls the pipeline until it finishes.
//  The returned read word is held stable for the load-extract logic that consumes
//  readdataM, until the pipeline advances past the instruction.
// PARAMETERS
//  ADDR_WIDTH  32  width of data_addr / bus addr
//  DATA_WIDTH  32  width of write/read data (4 byte lanes at 32)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous reset, active high
//  cpu_en         in   1   M-stage access valid (load/store, no addr error/exception)
//  cpu_wen        in   4   byte-lane write enables; nonzero = store
//  cpu_size       in   2   0=byte 1=half 2=word (3 treated as word)
//  cpu_addr       in   ADDR_WIDTH  byte address
//  cpu_wdata      in   DATA_WIDTH  lane-aligned store data
//  cpu_rdata      out  DATA_WIDTH  read word returned to load-extract logic
//  flush          in   1   exception flush of the M-stage instruction
//  longest_stall  in   1   global pipeline stall (any source, including this block)
//  d_stall        out  1   stall request from this block
//  data_req       out  1   sram-like request
//  data_wr        out  1   1=write 0=read
//  data_size      out  2   access size, same encoding as cpu_size
//  data_addr      out  ADDR_WIDTH  request address
//  data_wdata     out  DATA_WIDTH  request write data
//  data_addr_ok   in   1   request accepted (handshake with data_req)
//  data_data_ok   in   1   transaction complete / read data valid
//  data_rdata     in   DATA_WIDTH  bus read data, valid with data_data_ok
// BEHAVIOUR
//  FSM states IDLE, ADDR, DATA, HOLD; reset -> IDLE, discard=0.
//  Reset values: data_req=0 data_wr=0 data_size=0 data_addr=0 data_wdata=0 cpu_rdata=0.
//  IDLE: on cpu_en & !flush latch wr=|cpu_wen, size, addr, wdata -> ADDR. Otherwise stay.
//  ADDR: data_req=1 with latched fields, held unchanged until data_addr_ok.
//   addr_ok & !data_ok -> DATA; addr_ok & data_ok same cycle -> completion (below).
//  DATA: data_req=0; wait data_data_ok -> completion.
//  Completion: reads capture data_rdata into cpu_rdata; writes load cpu_rdata=0.
//   If discard=1 -> IDLE, clear discard; else -> HOLD.
//  HOLD: no request; cpu_rdata held; stay while longest_stall=1; when 0 -> IDLE
//   (pipeline advances this cycle). HOLD never reissues even though cpu_en stays high.
//  d_stall = (IDLE & cpu_en & !flush) | ADDR | DATA; 0 in HOLD; 0 during rst.
//  Latency: request visible 1 cycle after cpu_en seen in IDLE; d_stall drops the
//   cycle after data_data_ok.
//  flush in IDLE: no request issued. flush in ADDR/DATA: request is NOT withdrawn
//   (bus rule: req held until addr_ok); set discard=1, keep d_stall high until
//   data_ok, then IDLE without HOLD and without updating cpu_rdata. flush in HOLD -> IDLE.
//  data_data_ok in IDLE/HOLD is ignored. rst mid-transaction -> IDLE immediately;
//   bus side is reset alongside.
//  data_wdata/data_addr are the latched copies, independent of cpu_* after IDLE.
// TESTING
//  Word load addr=0x8000_0010, addr_ok 2 cycles after req, data_ok 3 later,
//   rdata=0xDEAD_BEEF -> one req handshake, cpu_rdata=0xDEADBEEF in HOLD, d_stall 0 then.
//  Byte store wen=4'b0100 wdata=0x00AB_0000 addr=...2, addr_ok+data_ok same cycle
//   -> data_wr=1 size=0, direct to HOLD, cpu_rdata=0.
//  flush 1 cycle after req rises, addr_ok delayed 3 cycles -> req held to addr_ok,
//   d_stall high until data_ok, then IDLE, no HOLD, cpu_rdata unchanged.
//  HOLD with longest_stall=1 for 4 cycles -> no new req, cpu_rdata stable, IDLE after.
//  Back-to-back load then store -> exactly two req handshakes, second data_addr correct.
//  rst pulsed while in DATA -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/data_sram_like_if.sv
// ---------------------------------------------------------------------------
// data_sram_like_if
// Data-side bus front end of the M stage. Converts one per-instruction data
// access into a sram-like request/addr_ok/data_ok transaction, stalls the
// pipeline until it completes, and holds the returned read word stable until
// the pipeline advances past the instruction.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cpu_en          M-stage access valid
//   cpu_wen         byte-lane write enables (nonzero = store)
//   cpu_size        0=byte 1=half 2=word (3 handled as word)
//   cpu_addr        byte address
//   cpu_wdata       lane-aligned store data
//   cpu_rdata       read word held for the load-extract logic
//   flush           exception flush of the M-stage instruction
//   longest_stall   global pipeline stall
//   d_stall         stall request from this block (combinational)
//   data_req/wr/size/addr/wdata   sram-like request side
//   data_addr_ok/data_data_ok/data_rdata   sram-like response side
// ---------------------------------------------------------------------------
module data_sram_like_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic [3:0]            cpu_wen,
    input  logic [1:0]            cpu_size,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  flush,
    input  logic                  longest_stall,
    output logic                  d_stall,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_WIDTH-1:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    discard;
    logic                    discard_next;
    logic                    req_next;
    logic                    wr_next;
    logic [1:0]              size_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [DATA_WIDTH-1:0]   rdata_next;
    logic                    complete;
    logic                    drop;

    // Next-state and next-register values
    always_comb begin
        state_next   = state;
        discard_next = discard;
        req_next     = 1'b0;
        wr_next      = data_wr;
        size_next    = data_size;
        addr_next    = data_addr;
        wdata_next   = data_wdata;
        rdata_next   = cpu_rdata;
        complete     = 1'b0;
        drop         = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_en && !flush) begin
                    state_next = ADDR;
                    req_next   = 1'b1;
                    wr_next    = |cpu_wen;
                    size_next  = (cpu_size == 2'd3) ? 2'd2 : cpu_size;
                    addr_next  = cpu_addr;
                    wdata_next = cpu_wdata;
                end
            end
            ADDR: begin
                // The request stays up until accepted, even across a flush.
                req_next = 1'b1;
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (data_addr_ok) begin
                    req_next = 1'b0;
                    if (data_data_ok) begin
                        complete = 1'b1;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (data_data_ok) begin
                    complete = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !longest_stall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A flush arriving in the completion cycle itself also discards.
        if (complete) begin
            drop         = discard || flush;
            discard_next = 1'b0;
            if (drop) begin
                state_next = IDLE;
            end else begin
                state_next = HOLD;
                rdata_next = data_wr ? '0 : data_rdata;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            discard    <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            cpu_rdata  <= '0;
        end else begin
            state      <= state_next;
            discard    <= discard_next;
            data_req   <= req_next;
            data_wr    <= wr_next;
            data_size  <= size_next;
            data_addr  <= addr_next;
            data_wdata <= wdata_next;
            cpu_rdata  <= rdata_next;
        end
    end

    // Stall must assert in the same cycle the access is first seen.
    assign d_stall = !rst && (((state == IDLE) && cpu_en && !flush)
                              || (state == ADDR) || (state == DATA));

endmodule

// File: tb/tb_data_sram_like_if.sv
`timescale 1ns/1ps
module tb_data_sram_like_if;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_en;
    logic [3:0]    cpu_wen;
    logic [1:0]    cpu_size;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          flush;
    logic          ext_stall;
    logic          longest_stall;
    logic          d_stall;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    int checks    = 0;
    int passed    = 0;
    int hs_count  = 0;
    int hs_expect = 0;
    logic [DW-1:0] model_rdata;

    always #5 clk = ~clk;

    assign longest_stall = d_stall | ext_stall;

    data_sram_like_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .flush        (flush),
        .longest_stall(longest_stall),
        .d_stall      (d_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    // Count accepted request handshakes on the bus
    always @(posedge clk) begin
        if (!rst && data_req && data_addr_ok) hs_count <= hs_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One access: issue, bus responses after the given delays, optional
    // flush pulse at transaction cycle fl_at, then hold for 'hold' cycles.
    task automatic run_txn(input bit st, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input int aok, input int dok, input int fl_at,
                           input int hold, input bit hflush);
        logic [3:0] wen;
        logic [1:0] esz;
        bit         flushed;
        int         cyc;
        esz = (sz == 2'd3) ? 2'd2 : sz;
        wen = 4'b0000;
        if (st) begin
            case (esz)
                2'd0:    wen = 4'b0001 << addr[1:0];
                2'd1:    wen = addr[1] ? 4'b1100 : 4'b0011;
                default: wen = 4'b1111;
            endcase
        end
        flushed = 1'b0;
        cyc = 0;

        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = wen; cpu_size = sz; cpu_addr = addr; cpu_wdata = wdata;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; ext_stall = 1'b0;
        #1 check("stall_idle", d_stall, 1);

        for (int i = 0; i <= aok; i++) begin
            @(negedge clk);
            check("req_hi", data_req, 1);
            check("req_addr", data_addr, addr);
            check("req_wr", data_wr, st);
            check("req_size", data_size, esz);
            check("req_wdata", data_wdata, wdata);
            cpu_addr = $urandom; cpu_wdata = $urandom;
            cpu_wen = 4'($urandom); cpu_size = 2'($urandom);
            flush = (cyc == fl_at);
            if (flush) flushed = 1'b1;
            data_addr_ok = (i == aok);
            data_data_ok = (i == aok) && (dok == 0);
            data_rdata = data_data_ok ? rd : $urandom;
            #1 check("stall_addr", d_stall, 1);
            cyc++;
        end

        for (int j = 1; j <= dok; j++) begin
            @(negedge clk);
            check("req_lo_data", data_req, 0);
            data_addr_ok = 1'b0;
            flush = (cyc == fl_at);
            if (flush) flushed = 1'b1;
            data_data_ok = (j == dok);
            data_rdata = data_data_ok ? rd : $urandom;
            #1 check("stall_data", d_stall, 1);
            cyc++;
        end
        hs_expect++;

        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0; data_rdata = $urandom;
        if (flushed) begin
            cpu_en = 1'b0;
            #1;
            check("stall_after_flush", d_stall, 0);
            check("req_after_flush", data_req, 0);
            check("rdata_kept_flush", cpu_rdata, model_rdata);
        end else begin
            model_rdata = st ? 32'h0 : rd;
            ext_stall = (hold > 0);
            #1;
            check("done_rdata", cpu_rdata, model_rdata);
            check("done_req", data_req, 0);
            check("done_stall", d_stall, 0);
            for (int k = 1; k <= hold; k++) begin
                @(negedge clk);
                check("hold_req", data_req, 0);
                check("hold_rdata", cpu_rdata, model_rdata);
                data_data_ok = 1'($urandom_range(0, 1));
                data_rdata = $urandom;
                if (k == hold) begin
                    if (hflush) flush = 1'b1;
                    else ext_stall = 1'b0;
                end
                #1 check("hold_stall", d_stall, 0);
            end
        end
    endtask

    // Access presented together with a flush while idle: nothing issued
    task automatic idle_flush();
        @(negedge clk);
        cpu_en = 1'b1; flush = 1'b1; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        cpu_addr = $urandom; cpu_wen = 4'($urandom);
        #1 check("stall_idle_flush", d_stall, 0);
        @(negedge clk);
        check("req_idle_flush", data_req, 0);
        cpu_en = 1'b0; flush = 1'b0;
        #1 check("stall_idle_after", d_stall, 0);
    endtask

    initial begin
        int hs_before;
        rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_size = 2'd0; cpu_addr = '0;
        cpu_wdata = '0; flush = 1'b0; ext_stall = 1'b0; data_addr_ok = 1'b0;
        data_data_ok = 1'b0; data_rdata = '0;
        model_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", data_req, 0);
        check("rst_wr", data_wr, 0);
        check("rst_size", data_size, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_stall", d_stall, 0);
        rst = 1'b0;

        // Directed scenarios
        run_txn(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2, 3, -1, 2, 1'b0);
        run_txn(1'b1, 2'd0, 32'h8000_0012, 32'h00AB_0000, 32'h1111_2222, 0, 0, -1, 1, 1'b0);
        run_txn(1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'h5555_AAAA, 3, 2, 1, 0, 1'b0);
        run_txn(1'b0, 2'd1, 32'h8000_0032, 32'h0, 32'hCAFE_F00D, 1, 1, -1, 4, 1'b0);
        hs_before = hs_count;
        run_txn(1'b0, 2'd2, 32'h8000_0040, 32'h0, 32'h0123_4567, 0, 1, -1, 0, 1'b0);
        run_txn(1'b1, 2'd2, 32'h8000_0044, 32'h89AB_CDEF, 32'h0, 1, 0, -1, 0, 1'b0);
        check("b2b_handshakes", 64'(hs_count - hs_before), 64'd2);
        run_txn(1'b0, 2'd3, 32'h8000_0050, 32'h0, 32'h7777_8888, 0, 0, -1, 2, 1'b1);
        idle_flush();

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            int aok, dok, fl_at, hold;
            bit hfl;
            aok   = int'($urandom_range(0, 4));
            dok   = int'($urandom_range(0, 4));
            fl_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, aok + dok)) : -1;
            hold  = int'($urandom_range(0, 3));
            hfl   = (hold > 0) && ($urandom_range(0, 5) == 0);
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom, aok, dok, fl_at, hold, hfl);
            if ($urandom_range(0, 9) == 0) idle_flush();
        end

        // Reset while waiting for data_ok
        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = 32'h1234_5678;
        flush = 1'b0; ext_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(negedge clk);
        check("rstseq_req", data_req, 1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        check("rstseq_req_lo", data_req, 0);
        rst = 1'b1; cpu_en = 1'b0;
        #1 check("stall_in_rst", d_stall, 0);
        hs_expect++;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_req", data_req, 0);
        check("rst2_wr", data_wr, 0);
        check("rst2_size", data_size, 0);
        check("rst2_addr", data_addr, 0);
        check("rst2_wdata", data_wdata, 0);
        check("rst2_rdata", cpu_rdata, 0);
        check("rst2_stall", d_stall, 0);
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        data_data_ok = 1'b0;
        check("stray_dok_rdata", cpu_rdata, 0);
        check("stray_dok_req", data_req, 0);
        check("stray_dok_stall", d_stall, 0);

        check("handshake_total", 64'(hs_count), 64'(hs_expect));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
